// File: rtl/regfile_sb.sv
// Register file with a per-register busy/tag scoreboard for out-of-order writeback.
// After reset an INIT sweep clears every entry; ready rises when the sweep completes.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic [TAGW-1:0] iss_tag,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [TAGW-1:0] wb_tag,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            re1,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  output logic            rbusy1,
  output logic [TAGW-1:0] rtag1,
  input  logic            re2,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  output logic            rbusy2,
  output logic [TAGW-1:0] rtag2
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] data_q [NREG];
  logic [XLEN-1:0] data_d [NREG];
  logic [TAGW-1:0] tag_q  [NREG];
  logic [TAGW-1:0] tag_d  [NREG];
  logic [NREG-1:0] busy_q, busy_d;

  logic run;
  logic wb_hit;
  logic iss_ok;

  assign run    = (state_q == RUN);
  // A writeback only lands if the register still waits on exactly this tag.
  assign wb_hit = run && wb_en && (wb_addr != '0) && busy_q[wb_addr]
                  && (tag_q[wb_addr] == wb_tag);
  assign iss_ok = run && iss_en && (iss_addr != '0) && !flush;
  assign ready  = ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    case (state_q)
      INIT: begin
        data_d[cnt_q] = '0;
        busy_d[cnt_q] = 1'b0;
        tag_d[cnt_q]  = '0;
        cnt_d         = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) state_d = RUN;
      end
      RUN: begin
        if (wb_hit) begin
          data_d[wb_addr] = wb_data;
          busy_d[wb_addr] = 1'b0;
        end
        // Issue applied after writeback so a same-cycle pair leaves the entry busy.
        if (iss_ok) begin
          busy_d[iss_addr] = 1'b1;
          tag_d[iss_addr]  = iss_tag;
        end
        if (flush) busy_d = '0;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  // Read port 1: same-cycle matching writeback is forwarded, issue is not.
  always_comb begin
    rdata1 = '0;
    rbusy1 = 1'b0;
    rtag1  = '0;
    if (run && re1 && (raddr1 != '0)) begin
      rtag1 = tag_q[raddr1];
      if (wb_hit && (wb_addr == raddr1)) begin
        rdata1 = wb_data;
        rbusy1 = 1'b0;
      end else begin
        rdata1 = data_q[raddr1];
        rbusy1 = busy_q[raddr1];
      end
    end
  end

  // Read port 2: identical behaviour, independent address.
  always_comb begin
    rdata2 = '0;
    rbusy2 = 1'b0;
    rtag2  = '0;
    if (run && re2 && (raddr2 != '0)) begin
      rtag2 = tag_q[raddr2];
      if (wb_hit && (wb_addr == raddr2)) begin
        rdata2 = wb_data;
        rbusy2 = 1'b0;
      end else begin
        rdata2 = data_q[raddr2];
        rbusy2 = busy_q[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected read results,
// a negedge monitor pops and compares them against both read ports.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [3:0]  iss_tag;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [3:0]  wb_tag;
  logic [31:0] wb_data;
  logic        flush;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        rbusy1, rbusy2;
  logic [3:0]  rtag1, rtag2;

  typedef struct {
    logic [31:0] d;
    logic        b;
    logic [3:0]  t;
    string       nm;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  regfile_sb #(.XLEN(32), .NREG(32), .AW(5), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
    .flush(flush),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .rbusy1(rbusy1), .rtag1(rtag1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2), .rbusy2(rbusy2), .rtag2(rtag2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [31:0] gd, input logic gb, input logic [3:0] gt,
                     input logic [31:0] xd, input logic xb, input logic [3:0] xt);
    n_vec++;
    if (gd !== xd || gb !== xb || gt !== xt) begin
      n_err++;
      $display("FAIL %s: got d=%h b=%0b t=%0d, want d=%h b=%0b t=%0d", nm, gd, gb, gt, xd, xb, xt);
    end
  endtask

  task automatic chk_ready(input logic x, input string nm);
    n_vec++;
    if (ready !== x) begin
      n_err++;
      $display("FAIL %s: ready=%0b want %0b", nm, ready, x);
    end
  endtask

  task automatic idle();
    iss_en = 0; iss_addr = 0; iss_tag = 0;
    wb_en = 0; wb_addr = 0; wb_tag = 0; wb_data = 0;
    flush = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic [31:0] d, input logic b,
                    input logic [3:0] t, input string nm);
    exp_t e;
    e.d = d; e.b = b; e.t = t; e.nm = nm;
    if (p == 1) begin
      re1 = 1; raddr1 = a; q1.push_back(e);
    end else begin
      re2 = 1; raddr2 = a; q2.push_back(e);
    end
  endtask

  task automatic iss(input logic [4:0] a, input logic [3:0] t);
    iss_en = 1; iss_addr = a; iss_tag = t;
  endtask

  task automatic wb(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_tag = t; wb_data = d;
  endtask

  // Expect ready low for 32 cycles after release, high on the 33rd; reads stay 0 meanwhile.
  task automatic sweep(input string nm);
    for (int i = 0; i < 32; i++) begin
      chk_ready(1'b0, nm);
      rd(1, 5'd5, 32'h0, 1'b0, 4'd0, {nm, "_rd"});
      tick();
    end
    chk_ready(1'b1, {nm, "_done"});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (re1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL p1_underflow: got read with empty queue, want queued expectation");
        end else begin
          e1 = q1.pop_front();
          cmp({"p1_", e1.nm}, rdata1, rbusy1, rtag1, e1.d, e1.b, e1.t);
        end
      end else begin
        cmp("p1_idle", rdata1, rbusy1, rtag1, 32'h0, 1'b0, 4'd0);
      end
      if (re2) begin
        if (q2.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL p2_underflow: got read with empty queue, want queued expectation");
        end else begin
          e2 = q2.pop_front();
          cmp({"p2_", e2.nm}, rdata2, rbusy2, rtag2, e2.d, e2.b, e2.t);
        end
      end else begin
        cmp("p2_idle", rdata2, rbusy2, rtag2, 32'h0, 1'b0, 4'd0);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    sweep("init");

    // All registers clear after the sweep, port 2 walks the other way.
    for (int i = 0; i < 32; i++) begin
      rd(1, 5'(i), 32'h0, 1'b0, 4'd0, "clr");
      rd(2, 5'(31 - i), 32'h0, 1'b0, 4'd0, "clr");
      tick();
    end

    // Issue r5 tag 3, then matching writeback with bypass.
    iss(5'd5, 4'd3); rd(1, 5'd5, 32'h0, 1'b0, 4'd0, "r5_iss_nobypass"); tick();
    wb(5'd5, 4'd3, 32'hDEADBEEF);
    rd(1, 5'd5, 32'hDEADBEEF, 1'b0, 4'd3, "r5_bypass");
    rd(2, 5'd5, 32'hDEADBEEF, 1'b0, 4'd3, "r5_bypass");
    tick();
    rd(1, 5'd5, 32'hDEADBEEF, 1'b0, 4'd3, "r5_after"); tick();

    // Stale tag writeback is dropped.
    iss(5'd7, 4'd1); tick();
    iss(5'd7, 4'd2); rd(1, 5'd7, 32'h0, 1'b1, 4'd1, "r7_t1"); tick();
    wb(5'd7, 4'd1, 32'h11); rd(1, 5'd7, 32'h0, 1'b1, 4'd2, "r7_stale_wb"); tick();
    rd(1, 5'd7, 32'h0, 1'b1, 4'd2, "r7_after"); tick();

    // Issue and writeback to the same register in one cycle.
    iss(5'd9, 4'd2); tick();
    iss(5'd9, 4'd4); wb(5'd9, 4'd2, 32'h55);
    rd(1, 5'd9, 32'h55, 1'b0, 4'd2, "r9_same_cycle"); tick();
    rd(1, 5'd9, 32'h55, 1'b1, 4'd4, "r9_after"); tick();

    // Flush drops a same-cycle issue and clears every busy bit.
    iss(5'd3, 4'd5); tick();
    iss(5'd4, 4'd6); tick();
    flush = 1'b1; iss(5'd6, 4'd7);
    rd(1, 5'd3, 32'h0, 1'b1, 4'd5, "r3_pre_flush");
    rd(2, 5'd4, 32'h0, 1'b1, 4'd6, "r4_pre_flush");
    tick();
    rd(1, 5'd3, 32'h0, 1'b0, 4'd5, "r3_flushed");
    rd(2, 5'd6, 32'h0, 1'b0, 4'd0, "r6_dropped");
    tick();
    rd(1, 5'd4, 32'h0, 1'b0, 4'd6, "r4_flushed");
    rd(2, 5'd7, 32'h0, 1'b0, 4'd2, "r7_flushed");
    tick();
    rd(1, 5'd9, 32'h55, 1'b0, 4'd4, "r9_flushed"); tick();

    // Matching writeback alongside flush still writes data.
    iss(5'd10, 4'd1); tick();
    flush = 1'b1; wb(5'd10, 4'd1, 32'hA5A5A5A5); tick();
    rd(1, 5'd10, 32'hA5A5A5A5, 1'b0, 4'd1, "r10_flush_wb"); tick();

    // Writeback to a non-busy register is ignored.
    wb(5'd5, 4'd3, 32'h1234);
    rd(1, 5'd5, 32'hDEADBEEF, 1'b0, 4'd3, "r5_notbusy_wb"); tick();
    rd(1, 5'd5, 32'hDEADBEEF, 1'b0, 4'd3, "r5_notbusy_after"); tick();

    // Register 0 is hardwired.
    iss(5'd0, 4'd3); wb(5'd0, 4'd3, 32'hFF);
    rd(1, 5'd0, 32'h0, 1'b0, 4'd0, "r0_same"); tick();
    rd(1, 5'd0, 32'h0, 1'b0, 4'd0, "r0_after");
    rd(2, 5'd0, 32'h0, 1'b0, 4'd0, "r0_after");
    tick();

    // Reset mid-run, then again mid-INIT; each restarts the full sweep.
    rst = 1'b0; tick();
    chk_ready(1'b0, "rst_run_drop");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk_ready(1'b0, "rst_partial");
      tick();
    end
    rst = 1'b0; tick();
    rst = 1'b1;
    sweep("resweep");
    rd(1, 5'd5, 32'h0, 1'b0, 4'd0, "r5_cleared");
    rd(2, 5'd10, 32'h0, 1'b0, 4'd0, "r10_cleared");
    tick();

    @(negedge clk);
    n_vec++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q1.size(), q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width in bits.
REQ-002 Parameter NREG, default 32: number of architectural registers; power of two, at least 4.
REQ-003 Parameter AW, default 5: address width; equals log2(NREG).
REQ-004 Parameter TAGW, default 4: rename tag width in bits.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset; synchronous, active-low.
REQ-007 ready  out  1  high once the init sweep is complete.
REQ-008 iss_en / iss_addr / iss_tag  in  1 / AW / TAGW  issue: mark iss_addr busy, owned by iss_tag.
REQ-009 wb_en / wb_addr / wb_tag / wb_data  in  1 / AW / TAGW / XLEN  writeback of a result.
REQ-010 flush  in  1  clears every busy bit.
REQ-011 re{1,2} / raddr{1,2}  in  1 / AW  read enable and read address, per port.
REQ-012 rdata{1,2} / rbusy{1,2} / rtag{1,2}  out  XLEN / 1 / TAGW  combinational read results, per port.

Function
REQ-013 Per register, state is data[XLEN], busy, tag[TAGW]; register 0 always reads data 0, busy 0, tag 0.
REQ-014 FSM states: INIT, RUN; reset enters INIT with sweep counter 0.
REQ-015 INIT: writes data 0, busy 0, tag 0 to register[counter] each cycle and increments the counter.
REQ-016 INIT to RUN transition: after the cycle that writes index NREG-1; ready rises on the next edge, exactly NREG cycles after rst deasserts.
REQ-017 During INIT, issue, writeback and flush are ignored; read outputs are all 0.
REQ-018 RUN issue: iss_en with iss_addr nonzero sets busy=1 and tag=iss_tag at the next edge.
REQ-019 RUN writeback: wb_en with wb_addr nonzero, busy=1 and tag==wb_tag writes wb_data and clears busy; a stale tag or a non-busy register leaves all state unchanged.
REQ-020 Issue and writeback to the same register in one cycle: the data write follows REQ-019 against the pre-issue tag; busy stays 1 and tag takes iss_tag.
REQ-021 flush: clears all busy bits at the next edge; an issue in the same cycle is dropped; a matching writeback in the same cycle still writes data.
REQ-022 Read ports are combinational; re=0 or raddr=0 gives outputs 0/0/0.
REQ-023 Read bypass: when a valid matching writeback (REQ-019) targets raddr in the same cycle, rdata=wb_data and rbusy=0.
REQ-024 Issue in the same cycle is not bypassed: reads show pre-issue busy and tag.
REQ-025 The two read ports are independent and may address the same register.

Reset
REQ-026 When rst=0 at a rising edge: state becomes INIT, counter 0, ready 0.
REQ-027 Reset asserted in RUN or mid-INIT restarts the sweep from index 0.
REQ-028 Register contents are not defined to be zero until ready=1.

Verification
REQ-029 Release reset with NREG=32 -> ready=0 for 32 cycles, 1 on the 33rd; then every register reads 0 with busy 0.
REQ-030 Issue r5 tag 3, then writeback r5 tag 3 data 0xDEADBEEF -> in the wb cycle, a read of r5 returns 0xDEADBEEF with rbusy 0 (bypass); the next cycle reads the same.
REQ-031 Issue r7 tag 1, issue r7 tag 2, writeback r7 tag 1 data 0x11 -> r7 keeps its old data, busy 1, tag 2.
REQ-032 In one cycle: issue r9 tag 4 and writeback r9 tag 2 (current tag 2) data 0x55 -> r9 data 0x55, busy 1, tag 4.
REQ-033 Issue r3 and r4, then flush together with issue r6 -> all busy bits 0; r6 is not busy.
REQ-034 Issue and writeback to r0, then read r0 -> data 0, busy 0; assert reset mid-run -> ready drops and the sweep restarts.
